// File: rtl/dmem_port_if.sv
// Load/store port bundle between the RV32 core (master) and the data
// memory responder (slave). One request in flight, one-cycle response pulse.
interface dmem_port_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid,
        output req_we,
        output req_funct3,
        output req_addr,
        output req_wdata,
        input  req_ready,
        input  rsp_valid,
        input  rsp_rdata,
        input  rsp_err
    );

    modport slave (
        input  req_valid,
        input  req_we,
        input  req_funct3,
        input  req_addr,
        input  req_wdata,
        output req_ready,
        output rsp_valid,
        output rsp_rdata,
        output rsp_err
    );
endinterface

// File: rtl/dmem_port.sv
// Data-memory responder for the RV32 load/store port. Word-organised RAM,
// byte/halfword loads with sign/zero extension, sub-word stores done as a
// read-modify-write. Request fields are latched on acceptance (_p0), the
// RAM word read in RD is held in the _p1 register for extraction/merge.
module dmem_port #(
    parameter int DEPTH = 256
) (
    input  logic        clk,
    input  logic        reset,
    dmem_port_if.slave  bus
);

    localparam int DATA_W = 32;
    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        MERGE,
        WR,
        RESP
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [DATA_W-1:0] ram [DEPTH];

    // Request latched on acceptance; data fields carry no reset.
    logic              we_p0;
    logic [2:0]        f3_p0;
    logic [1:0]        lane_p0;
    logic [IDX_W-1:0]  idx_p0;
    logic [DATA_W-1:0] wdata_p0;
    logic              err_p0;

    // Word registered out of the RAM during RD.
    logic [DATA_W-1:0] rword_p1;

    logic              accept;
    logic              req_err;
    logic              ram_we;
    logic [DATA_W-1:0] wr_word;

    // Rejects illegal funct3 codes, misaligned halfword/word accesses and
    // word indices beyond the array.
    function automatic logic check_err(input logic we, input logic [2:0] f3,
                                       input logic [31:0] addr);
        logic bad_f3;
        logic misal;
        logic oob;
        if (we) begin
            bad_f3 = !((f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010));
        end else begin
            bad_f3 = !((f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
                       (f3 == 3'b100) || (f3 == 3'b101));
        end
        misal = ((f3[1:0] == 2'b01) && addr[0]) ||
                ((f3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
        oob   = ({2'b00, addr[31:2]} >= 32'(DEPTH));
        return bad_f3 | misal | oob;
    endfunction

    // Picks the addressed little-endian lane and extends it; funct3[2]
    // selects zero extension.
    function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                 input logic [2:0] f3,
                                                 input logic [1:0] lane);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (f3[1:0])
            2'b00:   res = {{24{b[7]  & ~f3[2]}}, b};
            2'b01:   res = {{16{h[15] & ~f3[2]}}, h};
            default: res = word;
        endcase
        return res;
    endfunction

    // Replaces only the addressed byte or halfword of the old word.
    function automatic logic [31:0] merge_word(input logic [31:0] word,
                                               input logic [31:0] wd,
                                               input logic [2:0] f3,
                                               input logic [1:0] lane);
        logic [31:0] res;
        res = word;
        if (f3[1:0] == 2'b00) begin
            case (lane)
                2'd0:    res[7:0]   = wd[7:0];
                2'd1:    res[15:8]  = wd[7:0];
                2'd2:    res[23:16] = wd[7:0];
                default: res[31:24] = wd[7:0];
            endcase
        end else if (lane[1]) begin
            res[31:16] = wd[15:0];
        end else begin
            res[15:0] = wd[15:0];
        end
        return res;
    endfunction

    assign accept  = bus.req_valid && (state_q == IDLE);
    assign req_err = check_err(bus.req_we, bus.req_funct3, bus.req_addr);

    // Writes happen only on the edge leaving WR or MERGE; an asserted reset
    // has already forced IDLE, so an aborted store never lands.
    assign ram_we  = ((state_q == WR) || (state_q == MERGE)) && reset;
    assign wr_word = (state_q == WR) ? wdata_p0
                                     : merge_word(rword_p1, wdata_p0, f3_p0, lane_p0);

    // State register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state selection: errors go straight to RESP, sw skips the read.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    if (req_err) begin
                        state_d = RESP;
                    end else if (bus.req_we && (bus.req_funct3 == 3'b010)) begin
                        state_d = WR;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            RD:      state_d = we_p0 ? MERGE : RESP;
            MERGE:   state_d = RESP;
            WR:      state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Response outputs are forced to zero outside RESP.
    always_comb begin
        bus.req_ready = (state_q == IDLE);
        bus.rsp_valid = 1'b0;
        bus.rsp_err   = 1'b0;
        bus.rsp_rdata = '0;
        if (state_q == RESP) begin
            bus.rsp_valid = 1'b1;
            bus.rsp_err   = err_p0;
            if (!err_p0 && !we_p0) begin
                bus.rsp_rdata = load_extract(rword_p1, f3_p0, lane_p0);
            end
        end
    end

    // ---- stage p0: request capture at acceptance ----
    always_ff @(posedge clk) begin
        if (accept) begin
            we_p0    <= bus.req_we;
            f3_p0    <= bus.req_funct3;
            lane_p0  <= bus.req_addr[1:0];
            idx_p0   <= bus.req_addr[IDX_W+1:2];
            wdata_p0 <= bus.req_wdata;
            err_p0   <= req_err;
        end
    end

    // ---- stage p1: RAM word registered during RD ----
    always_ff @(posedge clk) begin
        if (state_q == RD) begin
            rword_p1 <= ram[idx_p0];
        end
    end

    // RAM write port: whole word for sw, merged word for sb/sh.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[idx_p0] <= wr_word;
        end
    end

endmodule

// File: doc/dmem_port.md
# dmem_port

Data-memory responder for the RV32 core's load/store port. Accepts one load or store request at a time over a valid/ready handshake, holds a word-organised RAM, and performs byte/halfword extraction with sign or zero extension. Sub-word stores are done as a read-modify-write in the block. Each request produces a one-cycle response pulse carrying load data or an error flag.

## Interface
- DEPTH, 256, number of 32-bit words in the RAM array `RAM` (word index = addr[31:2]).
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request this cycle.
- req_we  input  1  1 = store, 0 = load.
- req_funct3  input  3  access size/sign, RISC-V funct3 encoding.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, unshifted (sb uses [7:0], sh uses [15:0]).
- rsp_valid  output  1  one-cycle response pulse.
- rsp_rdata  output  32  load result, valid with rsp_valid; 0 for stores and errors.
- rsp_err  output  1  request rejected, valid with rsp_valid.

## Operation
- States: IDLE, RD, MERGE, WR, RESP. req_ready = (state == IDLE).
- A request is accepted on a rising edge with req_valid & req_ready. addr, we, funct3 and wdata are latched on acceptance.
- Legal loads: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu.
- Legal stores: 000 sb, 001 sh, 010 sw.
- Error conditions:
  - any other funct3;
  - halfword with addr[0]=1;
  - word with addr[1:0]≠0;
  - addr[31:2] ≥ DEPTH.
  - On error: IDLE→RESP, rsp_err=1, rsp_rdata=0, RAM untouched.
- Load: IDLE→RD→RESP.
  - RD registers RAM[addr[31:2]].
  - Little-endian lanes: byte k is bits [8k+7:8k]. Byte lane = addr[1:0]; halfword lane = addr[1].
  - lb/lh sign-extend; lbu/lhu zero-extend; lw returns the whole word.
- sw: IDLE→WR→RESP. The RAM is written on the WR→RESP edge.
- sb/sh: IDLE→RD→MERGE→RESP.
  - MERGE replaces only the addressed byte or halfword of the registered word with wdata[7:0] or wdata[15:0].
  - The merged word is written on the MERGE→RESP edge.
- RESP: rsp_valid=1 for exactly one cycle, then →IDLE unconditionally. There is no response backpressure.
- rsp_rdata and rsp_err are held at 0 outside RESP.

## Timing
- Reset values: state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0. RAM contents are not cleared.
- Acceptance edge = E0. rsp_valid is high in the cycle after:
  - E0 for an error;
  - E1 for a load or sw;
  - E2 for sb/sh.
- req_ready is low from E0 until the edge that leaves RESP.
- Maximum throughput is one load or sw per 3 cycles, and one sb/sh per 4 cycles.
- Inputs are ignored while req_ready=0. A held req_valid is accepted on the first edge after return to IDLE.
- The RAM is read and written only in the states named above. No write ever happens on an error or load.
- Reset asserted mid-operation:
  - immediate return to IDLE with all outputs at reset values;
  - a store whose write edge has not occurred is dropped (RAM unchanged);
  - no response is issued for the aborted request.
- Reset deassertion is synchronised by the environment. The first acceptance can occur on the first edge with reset=1.

## Test plan
- Preload RAM[25]=0x8070F0A5, then issue loads (each pulses rsp_valid one cycle after E1, rsp_err=0):
  - lb 101 -> 0xFFFFFFF0
  - lbu 101 -> 0x000000F0
  - lh 102 -> 0xFFFF8070
  - lhu 100 -> 0x0000F0A5
  - lw 100 -> 0x8070F0A5
- Stores at address 96:
  - sw 96 wdata 0x00000019 -> RAM[24]=0x00000019, rsp pulse after E1 with rsp_rdata=0.
  - then sb 99 wdata 0x12345677 -> RAM[24]=0x77000019, rsp pulse after E2.
  - then sh 96 wdata 0xFFFFABCD -> RAM[24]=0x7700ABCD.
  - then lw 96 -> 0x7700ABCD.
- Errors (each: rsp_valid one cycle after E0, rsp_err=1, rsp_rdata=0, RAM unchanged):
  - lw 102
  - sh 97
  - load funct3=011 at 100
  - sw 1024 with DEPTH=256
- Handshake: req_valid held high with three back-to-back lw -> accepted at E0, E3, E6. req_ready is low for exactly two cycles after each acceptance, and exactly three rsp_valid pulses occur.
- Reset mid-op: RAM[24]=0x11223344, sb 96 wdata 0xAA accepted, reset driven low during MERGE before the write edge -> RAM[24] stays 0x11223344, rsp_valid stays 0, req_ready=1 immediately. After release, sb 96 wdata 0xAA -> RAM[24]=0x112233AA.
